// File: rtl/lsu_ram_port_if.sv
// Bundle of the CPU request/response handshake and the RAM port A bus seen by lsu_ram_port.
// The slave modport is the load/store unit; the master modport is whoever drives requests and models the RAM.
interface lsu_ram_port_if #(
    parameter int WIDTH = 32,
    parameter int BYTES = 4
);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_fault;
    logic [WIDTH-1:0] mem_addr;
    logic [BYTES-1:0] mem_we;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/lsu_ram_port.sv
// Load/store initiator for byte-enabled, word-addressed RAM port A with a 1-cycle registered read.
// Splits word-crossing accesses into two RAM cycles and aligns/extends load data.
module lsu_ram_port #(
    parameter int               BYTES            = 4,
    parameter int               WIDTH            = 32,
    parameter logic [WIDTH-1:0] MAX_ADDR         = 32'h0000_1000,
    parameter bit               ALLOW_MISALIGNED = 1'b1
) (
    input logic           clk,
    input logic           rst,
    lsu_ram_port_if.slave bus
);

    if (BYTES != 4 || WIDTH != BYTES * 8) begin : g_bytes_check
        $error("lsu_ram_port supports only BYTES=4, WIDTH=32");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACC1 = 3'd1,
        S_ACC2 = 3'd2,
        S_FIN  = 3'd3,
        S_RESP = 3'd4
    } state_e;

    state_e             state_q,      state_d;
    logic               req_ready_q,  req_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_fault_q, resp_fault_d;
    logic [WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic [WIDTH-1:0]   mem_addr_q,   mem_addr_d;
    logic [BYTES-1:0]   mem_we_q,     mem_we_d;
    logic [WIDTH-1:0]   mem_wdata_q,  mem_wdata_d;
    logic               write_q,      write_d;
    logic [1:0]         size_q,       size_d;
    logic               unsigned_q,   unsigned_d;
    logic [1:0]         off_q,        off_d;
    logic               split_q,      split_d;
    logic [BYTES-1:0]   be1_q,        be1_d;
    logic [WIDTH-1:0]   wd1_q,        wd1_d;
    logic [WIDTH-1:0]   lo_q,         lo_d;

    logic [1:0]         off_s;
    logic [3:0]         nb_s;
    logic [7:0]         mask_s;
    logic               misal_s;
    logic               split_s;
    logic               fault_s;
    logic [WIDTH-1:0]   w0_s;
    logic [2*WIDTH-1:0] wide_s;
    logic [2*WIDTH-1:0] pair_s;
    logic [2*WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0]   ext_s;

    // Request decode: lane mask, split detection, shifted store data and fault check.
    always_comb begin
        off_s = bus.req_addr[1:0];
        w0_s  = {2'b00, bus.req_addr[WIDTH-1:2]};
        case (bus.req_size)
            2'd0: begin
                nb_s    = 4'd1;
                mask_s  = 8'h01 << off_s;
                misal_s = 1'b0;
            end
            2'd1: begin
                nb_s    = 4'd2;
                mask_s  = 8'h03 << off_s;
                misal_s = off_s[0];
            end
            2'd2: begin
                nb_s    = 4'd4;
                mask_s  = 8'h0F << off_s;
                misal_s = (off_s != 2'd0);
            end
            default: begin
                nb_s    = 4'd8;
                mask_s  = 8'h00;
                misal_s = 1'b0;
            end
        endcase
        split_s = (({2'b00, off_s} + nb_s) > 4'd4);
        wide_s  = {{WIDTH{1'b0}}, bus.req_wdata} << {off_s, 3'b000};
        fault_s = (bus.req_size == 2'd3)
                | (!ALLOW_MISALIGNED && misal_s)
                | (w0_s >= MAX_ADDR)
                | (split_s && ((w0_s + {{(WIDTH-1){1'b0}}, 1'b1}) >= MAX_ADDR));
    end

    // Load alignment: join the two read words, shift the addressed byte to lane 0 and extend.
    always_comb begin
        pair_s    = split_q ? {bus.mem_rdata, lo_q} : {{WIDTH{1'b0}}, bus.mem_rdata};
        shifted_s = pair_s >> {off_q, 3'b000};
        case (size_q)
            2'd0:    ext_s = {{(WIDTH-8){~unsigned_q & shifted_s[7]}}, shifted_s[7:0]};
            2'd1:    ext_s = {{(WIDTH-16){~unsigned_q & shifted_s[15]}}, shifted_s[15:0]};
            default: ext_s = shifted_s[WIDTH-1:0];
        endcase
    end

    // Next-state and registered-output computation for the access sequencer.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_fault_d = 1'b0;
        resp_rdata_d = {WIDTH{1'b0}};
        mem_addr_d   = mem_addr_q;
        mem_we_d     = {BYTES{1'b0}};
        mem_wdata_d  = {WIDTH{1'b0}};
        write_d      = write_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        off_d        = off_q;
        split_d      = split_q;
        be1_d        = be1_q;
        wd1_d        = wd1_q;
        lo_d         = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    write_d    = bus.req_write;
                    size_d     = bus.req_size;
                    unsigned_d = bus.req_unsigned;
                    off_d      = off_s;
                    split_d    = split_s;
                    be1_d      = mask_s[7:4];
                    wd1_d      = wide_s[2*WIDTH-1:WIDTH];
                    if (fault_s) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else begin
                        state_d     = S_ACC1;
                        mem_addr_d  = w0_s;
                        mem_we_d    = bus.req_write ? mask_s[3:0] : {BYTES{1'b0}};
                        mem_wdata_d = wide_s[WIDTH-1:0];
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            S_ACC1: begin
                if (split_q) begin
                    state_d     = S_ACC2;
                    mem_addr_d  = mem_addr_q + {{(WIDTH-1){1'b0}}, 1'b1};
                    mem_we_d    = write_q ? be1_q : {BYTES{1'b0}};
                    mem_wdata_d = wd1_q;
                end else begin
                    state_d = S_FIN;
                end
            end
            // Read data for the low word arrives during ACC2.
            S_ACC2: begin
                lo_d    = bus.mem_rdata;
                state_d = S_FIN;
            end
            S_FIN: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = write_q ? {WIDTH{1'b0}} : ext_s;
                state_d      = S_RESP;
            end
            S_RESP: begin
                req_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= {WIDTH{1'b0}};
            mem_addr_q   <= {WIDTH{1'b0}};
            mem_we_q     <= {BYTES{1'b0}};
            mem_wdata_q  <= {WIDTH{1'b0}};
            write_q      <= 1'b0;
            size_q       <= 2'd0;
            unsigned_q   <= 1'b0;
            off_q        <= 2'd0;
            split_q      <= 1'b0;
            be1_q        <= {BYTES{1'b0}};
            wd1_q        <= {WIDTH{1'b0}};
            lo_q         <= {WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            write_q      <= write_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            off_q        <= off_d;
            split_q      <= split_d;
            be1_q        <= be1_d;
            wd1_q        <= wd1_d;
            lo_q         <= lo_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule
